datamux_scan_ctrl: RTL and testbench

Sequencer that drives the 2-bit SEL input of the datamux block. It steps SEL through channel pairs 0..3 at a programmable dwell rate, so the display path time-multiplexes the four 4-bit input buses. A requester can override the scan via a req/ack handshake to pin one channel, then release it. Sits between the top-level display control and datamux.

---
 rtl/datamux_scan_ctrl_pkg.sv | 13 +
 rtl/datamux_scan_ctrl_dwell_counter.sv | 34 +++
 rtl/datamux_scan_ctrl.sv | 94 +++++++++
 tb/tb_datamux_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/datamux_scan_ctrl_pkg.sv
// Shared state encodings and sizing constants for the datamux scan sequencer.
package datamux_scan_ctrl_pkg;

  localparam int SEL_W_DEF = 2;
  localparam int NUM_CH    = 2 ** SEL_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FORCED = 2'd2
  } state_t;

endpackage

// File: rtl/datamux_scan_ctrl_dwell_counter.sv
// Dwell counter: counts cycles on a channel and flags the terminal count.
// A DWELL of 0 behaves as 1; the >= compare copes with DWELL shrinking mid-count.
module datamux_scan_ctrl_dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic               o_tc
);

  logic [DWELL_W-1:0] r_count;
  logic [DWELL_W-1:0] w_limit;

  always_comb begin
    w_limit = '0;
    if (i_dwell != '0) w_limit = i_dwell - 1'b1;
  end

  assign o_tc = (r_count >= w_limit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/datamux_scan_ctrl.sv
// Scan sequencer for the datamux SEL input: round-robin channel stepping at a
// programmable dwell, with a req/ack override that pins one channel until released.
module datamux_scan_ctrl
  import datamux_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int SEL_W   = SEL_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic               FORCE_REQ,
  input  logic [SEL_W-1:0]   FORCE_SEL,
  input  logic               RELEASE,
  output logic [SEL_W-1:0]   SEL,
  output logic               STEP,
  output logic               FORCE_ACK,
  output logic               FORCED
);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_step;
  logic             r_ack;
  logic             r_forced;

  logic w_accept;
  logic w_cnt_en;
  logic w_tc;

  // A force request wins over both EN and a dwell advance due in the same cycle.
  assign w_accept = (r_state != ST_FORCED) && FORCE_REQ;
  assign w_cnt_en = (r_state == ST_SCAN) && EN && !FORCE_REQ;

  datamux_scan_ctrl_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (!w_cnt_en),
    .i_en    (w_cnt_en),
    .i_dwell (DWELL),
    .o_tc    (w_tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_step   <= 1'b0;
      r_ack    <= 1'b0;
      r_forced <= 1'b0;
    end else begin
      r_step <= 1'b0;
      r_ack  <= 1'b0;
      if (w_accept) begin
        r_state  <= ST_FORCED;
        r_sel    <= FORCE_SEL;
        r_ack    <= 1'b1;
        r_forced <= 1'b1;
        r_step   <= (FORCE_SEL != r_sel);
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (EN) r_state <= ST_SCAN;
          end
          ST_SCAN: begin
            if (!EN) begin
              r_state <= ST_IDLE;
            end else if (w_tc) begin
              r_sel  <= r_sel + 1'b1;
              r_step <= 1'b1;
            end
          end
          ST_FORCED: begin
            // Counter is held clear here, so a resumed scan gets a full dwell.
            if (RELEASE) begin
              r_forced <= 1'b0;
              r_state  <= EN ? ST_SCAN : ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign SEL       = r_sel;
  assign STEP      = r_step;
  assign FORCE_ACK = r_ack;
  assign FORCED    = r_forced;

endmodule

// File: tb/tb_datamux_scan_ctrl.sv
// Directed bench for datamux_scan_ctrl: scan, dwell edge cases, force handshake, reset.
module tb_datamux_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [15:0] DWELL;
  logic        FORCE_REQ;
  logic [1:0]  FORCE_SEL;
  logic        RELEASE;
  logic [1:0]  SEL;
  logic        STEP;
  logic        FORCE_ACK;
  logic        FORCED;

  int tests = 0;
  int fails = 0;

  datamux_scan_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .DWELL     (DWELL),
    .FORCE_REQ (FORCE_REQ),
    .FORCE_SEL (FORCE_SEL),
    .RELEASE   (RELEASE),
    .SEL       (SEL),
    .STEP      (STEP),
    .FORCE_ACK (FORCE_ACK),
    .FORCED    (FORCED)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] ex(input logic [1:0] s, input logic st,
                                    input logic ak, input logic fo);
    return {s, st, ak, fo};
  endfunction

  // Compares {SEL, STEP, FORCE_ACK, FORCED} against the expected tuple.
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] got;
    got = {SEL, STEP, FORCE_ACK, FORCED};
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got sel=%0d step=%0b ack=%0b forced=%0b, expected sel=%0d step=%0b ack=%0b forced=%0b",
             tag, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  logic [1:0] exp_sel [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                               2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
  int steps;

  initial begin
    RST = 1'b1; EN = 1'b0; DWELL = 16'd3;
    FORCE_REQ = 1'b0; FORCE_SEL = 2'd0; RELEASE = 1'b0;
    tick; tick;
    chk("reset_state", ex(2'd0, 0, 0, 0));
    RST = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle_hold", ex(2'd0, 0, 0, 0));
    end

    // Scan wrap at DWELL=3
    EN = 1'b1;
    tick;
    chk("scan_enter", ex(2'd0, 0, 0, 0));
    steps = 0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      chk($sformatf("scan_wrap_%0d", k), ex(exp_sel[k-1], (k % 3) == 0, 0, 0));
      if (STEP) steps++;
    end
    tests++;
    assert (steps === 4) else begin
      fails++;
      $error("FAIL scan_step_count: got %0d expected 4", steps);
    end

    // DWELL=0 steps every cycle
    DWELL = 16'd0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk($sformatf("dwell0_%0d", k), ex(2'(k), 1, 0, 0));
    end

    // Shrink DWELL 10 -> 2 at count 6
    DWELL = 16'd10;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("dwell10_hold", ex(2'd1, 0, 0, 0));
    end
    DWELL = 16'd2;
    tick; chk("shrink_advance", ex(2'd2, 1, 0, 0));
    tick; chk("shrink_mid",     ex(2'd2, 0, 0, 0));
    tick; chk("shrink_next",    ex(2'd3, 1, 0, 0));

    // Force arriving in the cycle an advance is due
    DWELL = 16'd4;
    tick; tick; tick;
    chk("pre_force", ex(2'd3, 0, 0, 0));
    FORCE_REQ = 1'b1; FORCE_SEL = 2'd2;
    tick;
    chk("force_accept", ex(2'd2, 1, 1, 1));
    FORCE_REQ = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick;
      chk("forced_hold", ex(2'd2, 0, 0, 1));
    end
    RELEASE = 1'b1;
    tick;
    RELEASE = 1'b0;
    chk("release_scan", ex(2'd2, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("resume_dwell", ex(2'd2, 0, 0, 0));
    end
    tick;
    chk("resume_advance", ex(2'd3, 1, 0, 0));

    RELEASE = 1'b1;
    tick;
    RELEASE = 1'b0;
    chk("release_ignored", ex(2'd3, 0, 0, 0));

    // Force from IDLE, release with EN=0
    EN = 1'b0;
    tick;
    chk("en_drop_idle", ex(2'd3, 0, 0, 0));
    FORCE_REQ = 1'b1; FORCE_SEL = 2'd1;
    tick;
    chk("idle_force", ex(2'd1, 1, 1, 1));
    FORCE_REQ = 1'b0;
    tick;
    chk("idle_forced_hold", ex(2'd1, 0, 0, 1));
    RELEASE = 1'b1;
    tick;
    RELEASE = 1'b0;
    chk("release_to_idle", ex(2'd1, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("idle_after_release", ex(2'd1, 0, 0, 0));
    end
    FORCE_REQ = 1'b1; FORCE_SEL = 2'd1;
    tick;
    chk("same_sel_force", ex(2'd1, 0, 1, 1));
    FORCE_REQ = 1'b0;

    // Asynchronous reset while forced, no clock edge
    RST = 1'b1;
    #2;
    chk("async_reset", ex(2'd0, 0, 0, 0));
    FORCE_REQ = 1'b1; FORCE_SEL = 2'd2; EN = 1'b1;
    tick;
    chk("reset_pending_req", ex(2'd0, 0, 0, 0));
    RST = 1'b0;
    tick;
    chk("post_reset_accept", ex(2'd2, 1, 1, 1));
    tick;
    chk("req_ignored_forced", ex(2'd2, 0, 0, 1));
    RELEASE = 1'b1;
    tick;
    RELEASE = 1'b0;
    FORCE_SEL = 2'd0;
    chk("release_req_held", ex(2'd2, 0, 0, 0));
    tick;
    chk("reaccept", ex(2'd0, 1, 1, 1));
    FORCE_REQ = 1'b0;
    tick;
    chk("reaccept_hold", ex(2'd0, 0, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
